// File: rtl/alu_pkg.sv
// Shared ALU definitions: loader FSM state encodings and opcode constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_pkg;

  // Loader FSM states; the encoding is shown directly on the status LEDs.
  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_e;

  localparam int OP_W = 6;

  // Opcodes understood by the alu core (MIPS-style function codes).
  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw pushbutton, emits a 1-cycle pulse on press.
// Latency: pulse is high DB_CYCLES+2 clocks after the first sampling edge.
// Backpressure: none; release of the button produces no pulse.
module button_debouncer #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Stability counter: only a disagreement lasting DB_CYCLES clocks flips stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and registered rising-edge pulse.
  // The pulse is registered so the loader sees a glitch-free, flop-driven strobe.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= i_btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      cnt_q        <= cnt_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_seq_input_ctrl.sv
// Steps A -> B -> Op -> SHOW on each debounced "next" press, loading one switch bank.
// Latency: field visible DB_CYCLES+3 clocks after the button is first sampled high.
// Backpressure: none; i_clear restarts the sequence and wins over a coincident press.
module alu_seq_input_ctrl
  import alu_pkg::*;
#(
  parameter int N         = 5,
  parameter int NSel      = 6,
  parameter int N_SW      = 16,
  parameter int DB_CYCLES = 1000000
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic [N_SW-1:0] i_sw,
  input  logic            i_next,
  input  logic            i_clear,
  output logic [N-1:0]    o_alu_A,
  output logic [N-1:0]    o_alu_B,
  output logic [NSel-1:0] o_alu_Op,
  output logic            o_valid,
  output logic [1:0]      o_state
);

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [NSel-1:0] op_q, op_d;
  logic            valid_q, valid_d;
  logic            next_pulse;

  // Switch bits above the operand/opcode widths are intentionally ignored.
  logic unused_sw;
  assign unused_sw = ^i_sw;

  button_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_next_db (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_btn    (i_next),
    .o_pulse  (next_pulse)
  );

  // Next-state and capture logic; clear discards any coincident press.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = 1'b0;
    if (i_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (next_pulse) begin
      case (state_q)
        S_A: begin
          a_d     = i_sw[N-1:0];
          state_d = S_B;
        end
        S_B: begin
          b_d     = i_sw[N-1:0];
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = i_sw[NSel-1:0];
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        default: begin
          // SHOW keeps all fields so the ALU result stays on the LEDs.
          state_d = S_A;
        end
      endcase
    end
  end

  // State and capture registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign o_alu_A  = a_q;
  assign o_alu_B  = b_q;
  assign o_alu_Op = op_q;
  assign o_valid  = valid_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_alu_seq_input_ctrl.sv
// Self-checking bench for alu_seq_input_ctrl with a short debounce window.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_seq_input_ctrl;
  import alu_pkg::*;

  localparam int N    = 5;
  localparam int NSEL = 6;
  localparam int NSW  = 16;
  localparam int DB   = 4;

  logic            clk;
  logic            rst_n;
  logic [NSW-1:0]  sw;
  logic            nxt;
  logic            clr;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [NSEL-1:0] alu_op;
  logic            valid;
  logic [1:0]      state;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  // Reference model: position in the 4-step cycle plus the captured fields.
  int m_state = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_op    = 0;
  int m_valid = 0;

  alu_seq_input_ctrl #(
    .N(N), .NSel(NSEL), .N_SW(NSW), .DB_CYCLES(DB)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_sw     (sw),
    .i_next   (nxt),
    .i_clear  (clr),
    .o_alu_A  (alu_a),
    .o_alu_B  (alu_b),
    .o_alu_Op (alu_op),
    .o_valid  (valid),
    .o_state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles during which o_valid is high.
  always @(negedge clk) if (valid === 1'b1) vcnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_press(input logic [15:0] s);
    case (m_state)
      0: m_a = int'(s[4:0]);
      1: m_b = int'(s[4:0]);
      2: begin
        m_op = int'(s[5:0]);
        m_valid++;
      end
      default: ;
    endcase
    m_state = (m_state + 1) % 4;
  endtask

  task automatic model_clear();
    m_state = 0;
    m_a = 0;
    m_b = 0;
    m_op = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"}, 32'(state), m_state);
    check({tag, "_A"}, 32'(alu_a), m_a);
    check({tag, "_B"}, 32'(alu_b), m_b);
    check({tag, "_Op"}, 32'(alu_op), m_op);
    check({tag, "_valid_cnt"}, vcnt, m_valid);
  endtask

  task automatic press(input logic [15:0] s, input int hold, input int rel);
    sw  = s;
    nxt = 1'b1;
    tick(hold);
    nxt = 1'b0;
    tick(rel);
  endtask

  typedef struct {
    logic [15:0] sw;
    logic [1:0]  st;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [5:0]  op;
    int          vc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [15:0] rsw;
    int          r;

    tbl[0] = '{16'hFFE7, 2'b01, 5'd7,  5'd0,  6'h00, 0};
    tbl[1] = '{16'hA5FD, 2'b10, 5'd7,  5'h1D, 6'h00, 0};
    tbl[2] = '{16'hFFE0, 2'b11, 5'd7,  5'h1D, 6'h20, 1};
    tbl[3] = '{16'h000A, 2'b00, 5'd7,  5'h1D, 6'h20, 1};
    tbl[4] = '{16'h7C0A, 2'b01, 5'h0A, 5'h1D, 6'h20, 1};

    rst_n = 1'b0;
    sw    = '0;
    nxt   = 1'b0;
    clr   = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Basic sequence, wrap from SHOW and fifth press, via the vector table.
    for (int i = 0; i < 5; i++) begin
      press(tbl[i].sw, 10, 10);
      model_press(tbl[i].sw);
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_A", i), 32'(alu_a), 32'(tbl[i].a));
      check($sformatf("tbl%0d_B", i), 32'(alu_b), 32'(tbl[i].b));
      check($sformatf("tbl%0d_Op", i), 32'(alu_op), 32'(tbl[i].op));
      check($sformatf("tbl%0d_valid_cnt", i), vcnt, tbl[i].vc);
      if (i == 2) begin
        check("basic_op_is_add", 32'(alu_op), 32'(OP_ADD));
        check("basic_alu_sum", 32'($signed(alu_a) + $signed(alu_b)), 32'd4);
      end
    end
    check_all("after_table");

    // Synchronous clear back to S_A.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_clear();
    check_all("clear");

    // Latency: A must change on sampling edge 0 + DB + 3, not earlier.
    sw  = 16'h0015;
    nxt = 1'b1;
    for (int k = 0; k <= DB + 2; k++) begin
      tick(1);
      check($sformatf("lat_edge%0d_A", k), 32'(alu_a), 32'd0);
    end
    tick(1);
    check("lat_capture_A", 32'(alu_a), 32'h15);
    model_press(sw);
    tick(20);
    check("lat_held_state", 32'(state), 32'd1);
    nxt = 1'b0;
    tick(12);
    check_all("latency");

    // Bounce rejection: 2-cycle toggles must never capture B.
    sw = 16'h000C;
    for (int k = 0; k < 5; k++) begin
      nxt = 1'b1;
      tick(2);
      nxt = 1'b0;
      tick(2);
    end
    check("bounce_state", 32'(state), 32'd1);
    check("bounce_B", 32'(alu_b), 32'd0);
    press(sw, 12, 12);
    model_press(sw);
    check_all("bounce_settled");

    // Clear coincident with the pulse in S_OP: clear wins, pulse is lost.
    sw  = 16'h0024;
    nxt = 1'b1;
    tick(DB + 3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_clear();
    check_all("clr_prio");
    tick(10);
    nxt = 1'b0;
    tick(12);
    check_all("clr_prio_after");

    // Randomized presses and clears against the model.
    for (int it = 0; it < 40; it++) begin
      r   = $urandom_range(0, 3);
      rsw = 16'($urandom);
      if (r == 0) begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        model_clear();
      end else begin
        press(rsw, $urandom_range(8, 14), $urandom_range(8, 14));
        model_press(rsw);
      end
      check_all($sformatf("rand%0d", it));
    end

    // Async reset in S_B with the button held.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_clear();
    sw  = 16'h0011;
    nxt = 1'b1;
    tick(10);
    model_press(sw);
    check("ar_pre_state", 32'(state), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("ar_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    sw = 16'h000E;
    for (int k = 0; k <= DB + 2; k++) begin
      tick(1);
      check($sformatf("ar_edge%0d_A", k), 32'(alu_a), 32'd0);
    end
    tick(1);
    check("ar_capture_A", 32'(alu_a), 32'h0E);
    model_press(sw);
    nxt = 1'b0;
    tick(12);
    check_all("ar_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
